// File: rtl/fetch_unit.sv
// fetch_unit: PC/IR fetch stage with req/ack program memory handshake and one-cycle execute window.
// Optional FETCH_TIMEOUT_EN: abandon a stalled fetch after TIMEOUT_CYCLES, execute a NOP and flag fetch_err.
module fetch_unit #(
    parameter int PC_WIDTH          = 8,
    parameter int PROGRAM_DataWidth = 16,
    parameter int TIMEOUT_CYCLES    = 15
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         mem_req,
    output logic [PC_WIDTH-1:0]          mem_adr,
    input  logic                         mem_ack,
    input  logic [PROGRAM_DataWidth-1:0] mem_data,
    output logic [PROGRAM_DataWidth-1:0] instruction,
    output logic                         instr_valid,
    input  logic                         cnt_wr_en,
    input  logic [PC_WIDTH-1:0]          literal_adr,
    input  logic                         halt,
    output logic [PC_WIDTH-1:0]          pc,
    output logic                         fetch_err
);
    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;
    state_t state, state_n;
    logic [PC_WIDTH-1:0] pc_n;
    logic [PROGRAM_DataWidth-1:0] ir, ir_n;
    logic req_n, valid_n, ack;
    assign mem_adr = pc;
    assign instruction = instr_valid ? ir : '0;
    // mem_req is only ever high in FETCH, so this also ignores ack elsewhere
    assign ack = mem_req && mem_ack;
`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt, wait_n;
    logic err_n;
`endif
    always_comb begin
        state_n = state;
        pc_n    = pc;
        ir_n    = ir;
        req_n   = mem_req;
        valid_n = 1'b0;
        case (state)
            FETCH: begin
                req_n = 1'b1;
                if (ack) begin
                    ir_n    = mem_data;
                    req_n   = 1'b0;
                    valid_n = 1'b1;
                    state_n = EXEC;
                end
            end
            EXEC: begin
                pc_n    = cnt_wr_en ? literal_adr : pc + 1'b1;
                req_n   = !halt;
                state_n = halt ? HALT : FETCH;
            end
            HALT: begin
                req_n   = !halt;
                state_n = halt ? HALT : FETCH;
            end
            default: state_n = FETCH;
        endcase
`ifdef FETCH_TIMEOUT_EN
        err_n  = fetch_err;
        wait_n = (state == FETCH && mem_req && !mem_ack) ? wait_cnt + 1'b1 : '0;
        if (state == FETCH && mem_req && !mem_ack && wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            ir_n    = '0;
            req_n   = 1'b0;
            valid_n = 1'b1;
            err_n   = 1'b1;
            state_n = EXEC;
        end
`endif
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= '0;
            ir          <= '0;
            mem_req     <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            ir          <= ir_n;
            mem_req     <= req_n;
            instr_valid <= valid_n;
        end
    end
`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt  <= '0;
            fetch_err <= 1'b0;
        end else begin
            wait_cnt  <= wait_n;
            fetch_err <= err_n;
        end
    end
`else
    assign fetch_err = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit; memory returns {~adr, adr} for each address.
module tb_fetch_unit;
    logic clk = 1'b0, reset = 1'b1, mem_ack = 1'b0, cnt_wr_en = 1'b0, halt = 1'b0;
    logic [15:0] mem_data = '0;
    logic [7:0]  literal_adr = '0;
    logic        mem_req, instr_valid, fetch_err;
    logic [7:0]  mem_adr, pc;
    logic [15:0] instruction;
    int checks = 0, fails = 0;
    logic [15:0] sb[$];

    fetch_unit dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_adr(mem_adr), .mem_ack(mem_ack),
        .mem_data(mem_data), .instruction(instruction), .instr_valid(instr_valid),
        .cnt_wr_en(cnt_wr_en), .literal_adr(literal_adr), .halt(halt), .pc(pc), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] word(input logic [7:0] a);
        return {~a, a};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [7:0] adr, input int dly, input int exp_wait,
                             input logic jmp, input logic [7:0] tgt, input logic hlt);
        int w = 0;
        logic [15:0] e;
        logic [7:0] exp_pc;
        while (mem_req !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        checks++;
        if (w != exp_wait) begin
            fails++;
            $display("FAIL req_latency adr=%h: got %0d cycles, expected %0d", adr, w, exp_wait);
        end
        checks++;
        if (mem_adr !== adr) begin
            fails++;
            $display("FAIL fetch_adr: got %h, expected %h", mem_adr, adr);
        end
        for (int i = 0; i < dly; i++) begin
            step();
            checks++;
            if ({mem_req, instr_valid, instruction, mem_adr} !== {1'b1, 1'b0, 16'h0000, adr}) begin
                fails++;
                $display("FAIL wait_state adr=%h cyc=%0d: req=%b valid=%b instr=%h adr=%h, expected req=1 valid=0 instr=0000 adr=%h",
                         adr, i, mem_req, instr_valid, instruction, mem_adr, adr);
            end
        end
        mem_ack = 1'b1;
        mem_data = word(adr);
        sb.push_back(word(adr));
        cnt_wr_en = jmp;
        literal_adr = tgt;
        halt = hlt;
        step();
        mem_ack = 1'b0;
        mem_data = 16'hDEAD;
        e = sb.pop_front();
        checks++;
        if (instr_valid !== 1'b1 || mem_req !== 1'b0 || instruction !== e) begin
            fails++;
            $display("FAIL exec adr=%h: valid=%b req=%b instr=%h, expected valid=1 req=0 instr=%h",
                     adr, instr_valid, mem_req, instruction, e);
        end
        step();
        cnt_wr_en = 1'b0;
        exp_pc = jmp ? tgt : adr + 8'd1;
        checks++;
        if (instr_valid !== 1'b0 || instruction !== 16'h0000 || pc !== exp_pc || mem_req !== !hlt) begin
            fails++;
            $display("FAIL post_exec adr=%h: valid=%b instr=%h pc=%h req=%b, expected valid=0 instr=0000 pc=%h req=%b",
                     adr, instr_valid, instruction, pc, mem_req, exp_pc, !hlt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        checks++;
        if ({mem_req, instr_valid, instruction, pc, fetch_err} !== '0) begin
            fails++;
            $display("FAIL reset_values: req=%b valid=%b instr=%h pc=%h err=%b, expected all 0",
                     mem_req, instr_valid, instruction, pc, fetch_err);
        end
        step();
        step();
        checks++;
        if (mem_req !== 1'b0 || pc !== 8'h00) begin
            fails++;
            $display("FAIL reset_hold: req=%b pc=%h, expected req=0 pc=00", mem_req, pc);
        end
        reset = 1'b0;
        run_instr(8'h00, 0, 1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_sequential();
        for (int a = 1; a < 5; a++) run_instr(8'(a), 0, 0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_wait();
        run_instr(8'h05, 3, 0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_jump();
        run_instr(8'h06, 0, 0, 1'b1, 8'h03, 1'b0);
        run_instr(8'h03, 0, 0, 1'b1, 8'h40, 1'b0);
        run_instr(8'h40, 0, 0, 1'b1, 8'hFF, 1'b0);
        run_instr(8'hFF, 0, 0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_halt();
        for (int a = 0; a < 7; a++) run_instr(8'(a), 0, 0, 1'b0, 8'h00, 1'b0);
        run_instr(8'h07, 0, 0, 1'b0, 8'h00, 1'b1);
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (mem_req !== 1'b0 || pc !== 8'h08 || instr_valid !== 1'b0) begin
                fails++;
                $display("FAIL halted: req=%b pc=%h valid=%b, expected req=0 pc=08 valid=0", mem_req, pc, instr_valid);
            end
        end
        mem_ack = 1'b0;
        halt = 1'b0;
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_adr !== 8'h08) begin
            fails++;
            $display("FAIL resume: req=%b adr=%h, expected req=1 adr=08", mem_req, mem_adr);
        end
        run_instr(8'h08, 0, 0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_reset_mid_fetch();
        step();
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_adr !== 8'h09) begin
            fails++;
            $display("FAIL mid_fetch_pre: req=%b adr=%h, expected req=1 adr=09", mem_req, mem_adr);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || pc !== 8'h00 || instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: req=%b pc=%h valid=%b, expected req=0 pc=00 valid=0", mem_req, pc, instr_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        run_instr(8'h00, 0, 1, 1'b0, 8'h00, 1'b0);
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        run_instr(8'h01, 14, 0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (fetch_err !== 1'b0) begin
            fails++;
            $display("FAIL ack_wins_timeout: err=%b, expected 0", fetch_err);
        end
        while (mem_req === 1'b1 && n < 40) begin
            n++;
            step();
        end
        checks++;
        if (n != 15) begin
            fails++;
            $display("FAIL timeout_len: req high %0d cycles, expected 15", n);
        end
        checks++;
        if (instr_valid !== 1'b1 || instruction !== 16'h0000 || fetch_err !== 1'b1) begin
            fails++;
            $display("FAIL timeout_nop: valid=%b instr=%h err=%b, expected valid=1 instr=0000 err=1",
                     instr_valid, instruction, fetch_err);
        end
        step();
        checks++;
        if (pc !== 8'h03 || mem_req !== 1'b1) begin
            fails++;
            $display("FAIL timeout_next: pc=%h req=%b, expected pc=03 req=1", pc, mem_req);
        end
        run_instr(8'h03, 0, 0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (fetch_err !== 1'b1) begin
            fails++;
            $display("FAIL err_sticky: err=%b, expected 1", fetch_err);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (fetch_err !== 1'b0) begin
            fails++;
            $display("FAIL err_reset: err=%b, expected 0", fetch_err);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask
`else
    task automatic test_timeout();
        run_instr(8'h01, 20, 0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (fetch_err !== 1'b0) begin
            fails++;
            $display("FAIL no_timeout_err: err=%b, expected 0", fetch_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_wait();
        test_jump();
        test_halt();
        test_reset_mid_fetch();
        test_timeout();
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_empty: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
